// File: rtl/mat_uart_sender_pkg.sv
// Shared definitions for the matrix-over-UART sender: frame geometry,
// default header byte, bit-level state encoding and the checksum helper.
package mat_uart_sender_pkg;

    // Frame header byte used when the instantiating design does not override it.
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // A frame is the header, nine matrix elements and one checksum byte.
    localparam int MAT_ELEMS   = 9;
    localparam int FRAME_BYTES = MAT_ELEMS + 2;
    localparam int MAT_WIDTH   = 8 * MAT_ELEMS;

    // Bit-level states of the 8N1 serializer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Checksum is the plain XOR of the nine elements (no carry, 8 bits).
    function automatic logic [7:0] mat_checksum(input logic [MAT_WIDTH-1:0] mat);
        logic [7:0] acc;
        acc = 8'h00;
        for (int k = 0; k < MAT_ELEMS; k++) begin
            acc = acc ^ mat[8*k +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/mat_uart_sender_if.sv
// Handshake/data bundle between a matrix producer and the UART sender.
// Signal names keep the i_/o_ direction view of the sender.
interface mat_uart_sender_if;
    import mat_uart_sender_pkg::*;

    logic                 i_start;
    logic [MAT_WIDTH-1:0] i_mat;
    logic                 o_tx;
    logic                 o_busy;
    logic                 o_done;

    // Producer side: requests frames and watches progress.
    modport master (
        output i_start,
        output i_mat,
        input  o_tx,
        input  o_busy,
        input  o_done
    );

    // Sender side.
    modport slave (
        input  i_start,
        input  i_mat,
        output o_tx,
        output o_busy,
        output o_done
    );

endinterface

// File: rtl/mat_uart_sender_uart_byte_tx.sv
// 8N1 byte serializer with its own bit timer. A byte is taken on
// i_valid && o_ready; o_ready is raised while idle and on the final cycle of
// the stop bit so that a following byte starts with no gap on the line.
module uart_byte_tx
    import mat_uart_sender_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

    tx_state_t   state_reg;
    logic [2:0]  bit_idx_reg;
    logic [TW-1:0] timer_reg;
    logic [7:0]  shift_reg;
    logic        tx_reg;

    logic bit_end;
    logic load;

    // The timer counts down from CLKS_PER_BIT-1; zero marks the last cycle of a bit.
    assign bit_end = (timer_reg == '0);

    // Ready when idle, or when the stop bit is about to end (back-to-back chaining).
    assign o_ready = (state_reg == IDLE) || ((state_reg == STOP) && bit_end);
    assign load    = i_valid && o_ready;

    assign o_tx = tx_reg;

    // Bit sequencer: start bit, 8 data bits LSB first, stop bit; line idles high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            bit_idx_reg <= 3'd0;
            timer_reg   <= '0;
            shift_reg   <= 8'h00;
            tx_reg      <= 1'b1;
        end else if (load) begin
            // New byte: drive the start bit from the very next cycle.
            state_reg   <= START;
            bit_idx_reg <= 3'd0;
            timer_reg   <= TIMER_RELOAD;
            shift_reg   <= i_data;
            tx_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg    <= 1'b1;
                    timer_reg <= '0;
                end
                START: begin
                    if (bit_end) begin
                        state_reg   <= DATA;
                        bit_idx_reg <= 3'd0;
                        timer_reg   <= TIMER_RELOAD;
                        tx_reg      <= shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                    end else begin
                        timer_reg <= timer_reg - TIMER_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer_reg <= TIMER_RELOAD;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        timer_reg <= timer_reg - TIMER_ONE;
                    end
                end
                STOP: begin
                    tx_reg <= 1'b1;
                    if (bit_end) begin
                        // No follow-on byte offered: fall back to idle.
                        state_reg <= IDLE;
                    end else begin
                        timer_reg <= timer_reg - TIMER_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    timer_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mat_uart_sender.sv
// Sends a 3x3 byte matrix as one UART frame: header, nine elements in
// row-major order, then the XOR checksum. The byte serializer does the bit
// timing; this level latches the matrix and feeds bytes in order.
module mat_uart_sender
    import mat_uart_sender_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 1250,
    parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mat_uart_sender_if.slave   bus
);

    localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

    logic                 busy_reg;
    logic                 done_reg;
    logic [3:0]           byte_idx_reg;   // byte currently on the line, 0..10
    logic [MAT_WIDTH-1:0] shadow_reg;

    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_line;

    logic       last_byte;
    logic [3:0] next_idx;
    logic [7:0] checksum;
    logic [7:0] elem [MAT_ELEMS];

    // Split the latched matrix into its nine bytes.
    generate
        for (genvar gi = 0; gi < MAT_ELEMS; gi++) begin : g_elem
            assign elem[gi] = shadow_reg[8*gi +: 8];
        end
    endgenerate

    assign checksum  = mat_checksum(shadow_reg);
    assign last_byte = (byte_idx_reg == LAST_BYTE);
    assign next_idx  = byte_idx_reg + 4'd1;

    // While idle, a start request offers the header straight to the serializer
    // so the start bit appears one cycle after i_start is sampled. During a
    // frame the following byte is offered until the checksum has been handed over.
    assign tx_valid = busy_reg ? !last_byte : bus.i_start;

    // Select the byte that follows the one currently on the line.
    always_comb begin
        tx_data = HEADER;
        if (busy_reg) begin
            if (next_idx == LAST_BYTE) begin
                tx_data = checksum;
            end else begin
                for (int k = 0; k < MAT_ELEMS; k++) begin
                    if (next_idx == 4'(k + 1)) begin
                        tx_data = elem[k];
                    end
                end
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (tx_valid),
        .i_data  (tx_data),
        .o_ready (tx_ready),
        .o_tx    (tx_line)
    );

    // Frame sequencer: accept a request only when idle, advance the byte index
    // at each stop-bit boundary, and pulse done once the checksum's stop bit ends.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            byte_idx_reg <= 4'd0;
            shadow_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            if (!busy_reg) begin
                if (bus.i_start) begin
                    busy_reg     <= 1'b1;
                    byte_idx_reg <= 4'd0;
                    shadow_reg   <= bus.i_mat;
                end
            end else if (tx_ready) begin
                if (last_byte) begin
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b1;
                    byte_idx_reg <= 4'd0;
                end else begin
                    byte_idx_reg <= next_idx;
                end
            end
        end
    end

    assign bus.o_tx   = tx_line;
    assign bus.o_busy = busy_reg;
    assign bus.o_done = done_reg;

endmodule

// File: tb/tb_mat_uart_sender.sv
// Scoreboard bench for mat_uart_sender at 4 clocks per bit. Stimulus pushes
// the expected frame bytes; an independent line decoder rebuilds bytes from
// o_tx and pops/compares them. Timing of start, busy and done is checked by
// the stimulus process against cycle counts derived from the frame rules.
module tb_mat_uart_sender;

    localparam int CPB          = 4;
    localparam int BYTE_SAMPLES = 10 * CPB;
    localparam int FRAME_CYCLES = 11 * 10 * CPB;   // 440
    localparam int DONE_AFTER   = FRAME_CYCLES + 1; // done pulse 441 cycles after i_start

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mat_uart_sender_if bus();

    mat_uart_sender #(
        .CLKS_PER_BIT (CPB),
        .HEADER       (8'hA5)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference frame: header, elements in row-major order, XOR of the elements.
    function automatic void push_frame(input logic [71:0] m);
        logic [7:0] cs;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(m[8*k +: 8]);
            cs = cs ^ m[8*k +: 8];
        end
        exp_q.push_back(cs);
    endfunction

    function automatic logic [71:0] rand_mat();
        logic [71:0] m;
        m[31:0]  = $urandom;
        m[63:32] = $urandom;
        m[71:64] = 8'($urandom);
        return m;
    endfunction

    // Line decoder: from the first low sample, collect one byte's worth of
    // per-cycle samples, then verify shape and compare against the scoreboard.
    logic [BYTE_SAMPLES-1:0] samp;
    int scnt = 0;

    task automatic finish_byte();
        logic       shape_ok;
        logic [7:0] got;
        logic [7:0] req;
        shape_ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
            for (int s = 0; s < CPB; s++) begin
                if (samp[b*CPB + s] !== samp[b*CPB]) shape_ok = 1'b0;
            end
        end
        if (samp[0] !== 1'b0) shape_ok = 1'b0;
        if (samp[9*CPB] !== 1'b1) shape_ok = 1'b0;
        for (int i = 0; i < 8; i++) got[i] = samp[(i+1)*CPB];
        checks++;
        if (!shape_ok) begin
            errors++;
            $display("FAIL byte_shape: samples(lsb=first)=%b, required start low %0d, stable bits, stop high", samp, CPB);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL byte_unexpected: got 0x%02h, required no byte", got);
        end else begin
            req = exp_q.pop_front();
            if (got !== req) begin
                errors++;
                $display("FAIL byte_value: got 0x%02h, required 0x%02h", got, req);
            end else begin
                $display("tx byte 0x%02h ok", got);
            end
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            scnt = 0;
        end else if (scnt > 0 || bus.o_tx === 1'b0) begin
            samp[scnt] = bus.o_tx;
            scnt++;
            if (scnt == BYTE_SAMPLES) begin
                finish_byte();
                scnt = 0;
            end
        end
    end

    // Issue a start pulse for matrix m; returns the cycle i_start was driven.
    task automatic start_frame(input logic [71:0] m, output int t_drive);
        @(negedge clk);
        bus.i_mat   = m;
        bus.i_start = 1'b1;
        push_frame(m);
        t_drive = cyc;
        $display("frame start at cycle %0d mat=%h", t_drive, m);
        @(negedge clk);
        bus.i_start = 1'b0;
        check("lat_tx", bus.o_tx, 1'b0);
        check("lat_busy", bus.o_busy, 1'b1);
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no o_done in 1000 cycles, required one");
        end
    endtask

    task automatic finish_frame(input int t_drive);
        int d;
        wait_done(d);
        if (d >= 0) begin
            check("done_cycle", d - t_drive, DONE_AFTER);
            check("done_busy", bus.o_busy, 1'b0);
            check("done_tx", bus.o_tx, 1'b1);
            check("frame_bytes_left", exp_q.size(), 0);
            @(negedge clk);
            check("done_one_cycle", bus.o_done, 1'b0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int d1;
        int d2;
        logic [71:0] m;
        logic tx_all_high;
        logic busy_any;
        logic done_seen;

        bus.i_start = 1'b0;
        bus.i_mat   = '0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", bus.o_tx, 1'b1);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_done", bus.o_done, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_tx", bus.o_tx, 1'b1);

        // Basic frame: elements 1..9, checksum 0x01.
        for (int k = 0; k < 9; k++) m[8*k +: 8] = 8'(k + 1);
        start_frame(m, t);
        finish_frame(t);

        // All ones: checksum 0xFF, start bits must still be low.
        m = {72{1'b1}};
        start_frame(m, t);
        finish_frame(t);

        // Requests and matrix changes during a frame are ignored.
        m = rand_mat();
        start_frame(m, t);
        while (cyc < t + 50) @(negedge clk);
        bus.i_mat = '0;
        while (cyc < t + 100) @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        finish_frame(t);
        tx_all_high = 1'b1;
        busy_any    = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (bus.o_tx !== 1'b1) tx_all_high = 1'b0;
            if (bus.o_busy !== 1'b0) busy_any = 1'b1;
        end
        check("no_requeue_tx", tx_all_high, 1'b1);
        check("no_requeue_busy", busy_any, 1'b0);

        // Mid-frame reset aborts the frame without a done pulse.
        m = rand_mat();
        start_frame(m, t);
        while (cyc < t + 200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx", bus.o_tx, 1'b1);
        check("abort_busy", bus.o_busy, 1'b0);
        exp_q.delete();
        done_seen   = 1'b0;
        tx_all_high = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) done_seen = 1'b1;
            if (bus.o_tx !== 1'b1) tx_all_high = 1'b0;
        end
        check("abort_no_done", done_seen, 1'b0);
        check("abort_line_idle", tx_all_high, 1'b1);
        m = rand_mat();
        start_frame(m, t);
        finish_frame(t);

        // Back-to-back: i_start held high, a new frame starts right after done.
        m = rand_mat();
        @(negedge clk);
        bus.i_mat   = m;
        bus.i_start = 1'b1;
        push_frame(m);
        t = cyc;
        $display("back-to-back start at cycle %0d mat=%h", t, m);
        @(negedge clk);
        check("b2b_lat_tx", bus.o_tx, 1'b0);
        wait_done(d1);
        if (d1 >= 0) begin
            check("b2b_done1", d1 - t, DONE_AFTER);
            check("b2b_bytes1", exp_q.size(), 0);
            push_frame(m);
            @(negedge clk);
            check("b2b_restart_tx", bus.o_tx, 1'b0);
            check("b2b_restart_busy", bus.o_busy, 1'b1);
            wait_done(d2);
            bus.i_start = 1'b0;
            if (d2 >= 0) begin
                check("b2b_period", d2 - d1, DONE_AFTER);
                check("b2b_bytes2", exp_q.size(), 0);
                @(negedge clk);
                check("b2b_stop_busy", bus.o_busy, 1'b0);
            end
        end
        bus.i_start = 1'b0;

        // Random frames with random idle gaps.
        for (int n = 0; n < 3; n++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            m = rand_mat();
            start_frame(m, t);
            finish_frame(t);
        end

        repeat (10) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mat_uart_sender.md
MAT_UART_SENDER -- requirements
Module: mat_uart_sender

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250, giving i_clk cycles per UART bit (9600 baud at 12 MHz).
REQ-002 SHALL have parameter HEADER, default 8'hA5, giving the frame header byte.
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_start  input  1  request to send the matrix present on i_mat.
REQ-006 SHALL have port i_mat  input  72  3x3 matrix, row-major; element k = i_mat[8k+7:8k], k=0..8.
REQ-007 SHALL have port o_tx  output  1  UART serial line, 8N1, idle high.
REQ-008 SHALL have port o_busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port o_done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 SHALL send a frame of 11 bytes in order: HEADER, element 0..8, checksum.
REQ-011 SHALL compute checksum as the bitwise XOR of elements 0..8, 8 bits wide with no carry.
REQ-012 SHALL send each byte as a start bit (0), then 8 data bits LSB first, then one stop bit (1), with no inter-byte gap.
REQ-013 SHALL hold each bit on o_tx for exactly CLKS_PER_BIT cycles, counted by a bit-timer that reloads at each bit boundary.
REQ-014 SHALL accept i_start only when o_busy is low, and on acceptance SHALL latch i_mat into a shadow register.
REQ-015 SHALL ignore later changes on i_mat during a frame.
REQ-016 SHALL ignore i_start while o_busy is high; such a request SHALL be neither queued nor counted.
REQ-017 SHALL use the states IDLE, START, DATA and STOP, with a 4-bit byte index (0..10) and a 3-bit bit index (0..7).
REQ-018 SHALL make the following transitions:
- IDLE -> START on accepted i_start.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after bit 7 completes.
- STOP -> START when byte index < 10, incrementing the byte index.
- STOP -> IDLE when byte index = 10.
REQ-019 SHALL drive o_tx low and o_busy high on the cycle after the cycle i_start is sampled high in IDLE (latency 1).
REQ-020 SHALL make a frame last exactly 110*CLKS_PER_BIT cycles, measured from the first start-bit cycle through the last stop-bit cycle.
REQ-021 SHALL, on the cycle after the last stop bit ends, return to IDLE with o_busy low and o_done high for exactly one cycle.
REQ-022 SHALL accept an i_start asserted on the o_done cycle, giving back-to-back frames with no extra idle bit.
REQ-023 SHALL drive o_tx high in IDLE and in STOP.

Reset
REQ-024 SHALL, while i_rst is high at a clock edge, set: state IDLE; o_tx 1; o_busy 0; o_done 0; byte index 0; bit index 0; bit-timer 0; shadow register 0.
REQ-025 SHALL, when i_rst is asserted mid-frame, abort the frame immediately: o_tx returns high on the next cycle and no o_done pulse is issued.
REQ-026 SHALL give i_rst priority over i_start in the same cycle.

Structure
REQ-027 SHALL take the state encoding, HEADER default, frame length (11), and matrix element count (9) from the shared project package.
REQ-028 SHALL implement the bit-level 8N1 shifter with its bit-timer as one sub-module, uart_byte_tx, with handshake i_valid/o_ready; mat_uart_sender sequences the bytes.

Verification (CLKS_PER_BIT=4)
REQ-029 SHALL check the basic frame:
- Stimulus: i_mat elements 1..9, one i_start pulse.
- Response: bytes A5,01..09,01 decoded; frame lasts 440 cycles; o_done once, at cycle 441 after i_start.
REQ-030 SHALL check the all-ones case:
- Stimulus: all elements FF.
- Response: checksum FF; every data bit 1; start bits still low for 4 cycles each.
REQ-031 SHALL check request handling while busy:
- Stimulus: i_start re-pulsed at cycle 100, and i_mat changed to all 00 at cycle 50.
- Response: a single frame identical to the original data.
REQ-032 SHALL check mid-frame reset:
- Stimulus: i_rst pulsed at cycle 200.
- Response: o_tx=1 and o_busy=0 the next cycle; no o_done; a new i_start then produces a correct full frame.
REQ-033 SHALL check back-to-back frames:
- Stimulus: i_start held high continuously.
- Response: consecutive frames, each 440 cycles, each START following the previous STOP with zero gap.
